// File: rtl/ex_stage_if.sv
// Bundles the execute stage's pipeline-facing signals.
// The master drives the decode, hazard and writeback inputs.
// The slave is the execute stage, which returns the E-stage and M-stage fields.
interface ex_stage_if #(
    parameter int WIDTH = 32
);
    // Hazard-unit controls.
    logic             FlushE;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;

    // Decode-stage fields.
    logic             RegWriteD;
    logic             MemToRegD;
    logic             MemWriteD;
    logic             ALUSrcD;
    logic             RegDstD;
    logic             MulD;
    logic             MfhiD;
    logic             MfloD;
    logic [2:0]       ALUControlD;
    logic [WIDTH-1:0] RD1D;
    logic [WIDTH-1:0] RD2D;
    logic [WIDTH-1:0] SignImmD;
    logic [4:0]       RsD;
    logic [4:0]       RtD;
    logic [4:0]       RdD;

    // Writeback value used for forwarding.
    logic [WIDTH-1:0] ResultW;

    // E-stage fields returned to the hazard unit.
    logic [4:0]       RsE;
    logic [4:0]       RtE;
    logic [4:0]       WriteRegE;
    logic             RegWriteE;
    logic             MemToRegE;
    logic             MulBusyE;

    // EX/MEM pipeline register.
    logic             RegWriteM;
    logic             MemToRegM;
    logic             MemWriteM;
    logic [WIDTH-1:0] ALUOutM;
    logic [WIDTH-1:0] WriteDataM;
    logic [4:0]       WriteRegM;

    modport master (
        output FlushE, ForwardAE, ForwardBE,
        output RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD,
        output MulD, MfhiD, MfloD, ALUControlD,
        output RD1D, RD2D, SignImmD, RsD, RtD, RdD, ResultW,
        input  RsE, RtE, WriteRegE, RegWriteE, MemToRegE, MulBusyE,
        input  RegWriteM, MemToRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM
    );

    modport slave (
        input  FlushE, ForwardAE, ForwardBE,
        input  RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD,
        input  MulD, MfhiD, MfloD, ALUControlD,
        input  RD1D, RD2D, SignImmD, RsD, RtD, RdD, ResultW,
        output RsE, RtE, WriteRegE, RegWriteE, MemToRegE, MulBusyE,
        output RegWriteM, MemToRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage of the pipelined MIPS core.
// The stage holds the ID/EX and EX/MEM registers, the forwarding muxes and the ALU.
// It also holds a background shift-add multiplier that writes its result into HI/LO.
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    ex_stage_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef struct packed {
        logic             regWrite;
        logic             memToReg;
        logic             memWrite;
        logic             aluSrc;
        logic             regDst;
        logic             mul;
        logic             mfhi;
        logic             mflo;
        logic [2:0]       aluControl;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] signImm;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
    } idEx_t;

    typedef struct packed {
        logic             regWrite;
        logic             memToReg;
        logic             memWrite;
        logic [WIDTH-1:0] aluOut;
        logic [WIDTH-1:0] writeData;
        logic [4:0]       writeReg;
    } exMem_t;

    typedef enum logic {IDLE, RUN} mulState_t;

    idEx_t              idExReg, idExNext;
    exMem_t             exMemReg, exMemNext;
    mulState_t          mulStateReg, mulStateNext;
    logic [WIDTH-1:0]   hiReg, loReg;
    logic [WIDTH-1:0]   mcandReg;
    logic [2*WIDTH-1:0] prodReg;
    logic [CNT_W-1:0]   cntReg;

    logic               mulBusy, mulStart, mulStep, mulLast;
    logic [WIDTH-1:0]   srcA, srcB, writeDataE, aluResult, aluOutE;
    logic [4:0]         writeRegE;
    logic [WIDTH:0]     sumUpper;
    logic [2*WIDTH-1:0] prodStep;

    // Selects the next ID/EX contents: a stall hold wins over a flush, so the E instruction is never lost.
    always_comb begin
        idExNext = idExReg;
        if (!mulBusy) begin
            if (bus.FlushE) begin
                idExNext = '0;
            end else begin
                idExNext.regWrite   = bus.RegWriteD;
                idExNext.memToReg   = bus.MemToRegD;
                idExNext.memWrite   = bus.MemWriteD;
                idExNext.aluSrc     = bus.ALUSrcD;
                idExNext.regDst     = bus.RegDstD;
                idExNext.mul        = bus.MulD;
                idExNext.mfhi       = bus.MfhiD;
                idExNext.mflo       = bus.MfloD;
                idExNext.aluControl = bus.ALUControlD;
                idExNext.rd1        = bus.RD1D;
                idExNext.rd2        = bus.RD2D;
                idExNext.signImm    = bus.SignImmD;
                idExNext.rs         = bus.RsD;
                idExNext.rt         = bus.RtD;
                idExNext.rd         = bus.RdD;
            end
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (reset) idExReg <= '0;
        else       idExReg <= idExNext;
    end

    // Forwarding muxes for both operands; codes 00 and 11 both select the register file.
    always_comb begin
        srcA = idExReg.rd1;
        case (bus.ForwardAE)
            2'b01:   srcA = bus.ResultW;
            2'b10:   srcA = exMemReg.aluOut;
            default: srcA = idExReg.rd1;
        endcase
        writeDataE = idExReg.rd2;
        case (bus.ForwardBE)
            2'b01:   writeDataE = bus.ResultW;
            2'b10:   writeDataE = exMemReg.aluOut;
            default: writeDataE = idExReg.rd2;
        endcase
        srcB      = idExReg.aluSrc ? idExReg.signImm : writeDataE;
        writeRegE = idExReg.regDst ? idExReg.rd : idExReg.rt;
    end

    // ALU with wrapping add/sub and signed set-less-than. MFHI and MFLO override the result.
    always_comb begin
        aluResult = '0;
        case (idExReg.aluControl)
            3'b010:  aluResult = srcA + srcB;
            3'b110:  aluResult = srcA - srcB;
            3'b000:  aluResult = srcA & srcB;
            3'b001:  aluResult = srcA | srcB;
            3'b111:  aluResult[0] = ($signed(srcA) < $signed(srcB));
            default: aluResult = '0;
        endcase
        aluOutE = idExReg.mfhi ? hiReg : (idExReg.mflo ? loReg : aluResult);
    end

    // Multiplier state register.
    always_ff @(posedge clk) begin
        if (reset) mulStateReg <= IDLE;
        else       mulStateReg <= mulStateNext;
    end

    // Multiplier next state: start on a MULT in E, and finish on the last counted step.
    always_comb begin
        mulStateNext = mulStateReg;
        case (mulStateReg)
            IDLE:    if (idExReg.mul && !mulBusy) mulStateNext = RUN;
            RUN:     if (cntReg == CNT_W'(1)) mulStateNext = IDLE;
            default: mulStateNext = IDLE;
        endcase
    end

    // Multiplier outputs. Only instructions that touch the multiplier stall while it runs.
    always_comb begin
        mulBusy  = (mulStateReg == RUN) && (idExReg.mul || idExReg.mfhi || idExReg.mflo);
        mulStart = (mulStateReg == IDLE) && idExReg.mul;
        mulStep  = (mulStateReg == RUN);
        mulLast  = mulStep && (cntReg == CNT_W'(1));
    end

    // One shift-add step: conditionally add the multiplicand to the upper half, then shift right.
    always_comb begin
        sumUpper = {1'b0, prodReg[2*WIDTH-1:WIDTH]} + (prodReg[0] ? {1'b0, mcandReg} : '0);
        prodStep = {sumUpper, prodReg[WIDTH-1:1]};
    end

    // Multiplier datapath and HI/LO. HI/LO change only when a product completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcandReg <= '0;
            prodReg  <= '0;
            cntReg   <= '0;
            hiReg    <= '0;
            loReg    <= '0;
        end else if (mulStart) begin
            mcandReg <= srcA;
            prodReg  <= {{WIDTH{1'b0}}, writeDataE};
            cntReg   <= CNT_W'(WIDTH);
        end else if (mulStep) begin
            prodReg <= prodStep;
            cntReg  <= cntReg - CNT_W'(1);
            if (mulLast) {hiReg, loReg} <= prodStep;
        end
    end

    // EX/MEM input: a held E instruction sends a bubble downstream so it is not issued twice.
    always_comb begin
        exMemNext.regWrite  = idExReg.regWrite;
        exMemNext.memToReg  = idExReg.memToReg;
        exMemNext.memWrite  = idExReg.memWrite;
        exMemNext.aluOut    = aluOutE;
        exMemNext.writeData = writeDataE;
        exMemNext.writeReg  = writeRegE;
        if (mulBusy) begin
            exMemNext.regWrite = 1'b0;
            exMemNext.memToReg = 1'b0;
            exMemNext.memWrite = 1'b0;
            exMemNext.writeReg = '0;
        end
    end

    // EX/MEM pipeline register.
    always_ff @(posedge clk) begin
        if (reset) exMemReg <= '0;
        else       exMemReg <= exMemNext;
    end

    assign bus.RsE        = idExReg.rs;
    assign bus.RtE        = idExReg.rt;
    assign bus.WriteRegE  = writeRegE;
    assign bus.RegWriteE  = idExReg.regWrite;
    assign bus.MemToRegE  = idExReg.memToReg;
    assign bus.MulBusyE   = mulBusy;
    assign bus.RegWriteM  = exMemReg.regWrite;
    assign bus.MemToRegM  = exMemReg.memToReg;
    assign bus.MemWriteM  = exMemReg.memWrite;
    assign bus.ALUOutM    = exMemReg.aluOut;
    assign bus.WriteDataM = exMemReg.writeData;
    assign bus.WriteRegM  = exMemReg.writeReg;
endmodule
